chk_verify_strip: RTL and testbench



---
 rtl/chk_verify_strip.sv | 164 ++++++++++++++++
 tb/tb_chk_verify_strip.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chk_verify_strip.sv
// Receive-side checksum verifier: forwards data beats with tlast moved onto the last data beat,
// strips the trailing checksum beat and pulses pass/fail. Optional counters: CHK_STATS_EN.
module chk_verify_strip #(
   parameter int AXIS_TDATA_WIDTH = 512,
   parameter int PID_BITS         = 8
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic [AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [AXIS_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic [PID_BITS-1:0]             s_axis_tid,
   input  logic                            s_axis_tlast,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   output logic [AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
   output logic [AXIS_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic [PID_BITS-1:0]             m_axis_tid,
   output logic                            m_axis_tlast,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            chk_ok,
   output logic                            chk_err,
   output logic                            runt_err,
   output logic [31:0]                     pkt_cnt,
   output logic [31:0]                     err_cnt
);

   typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t                          state_r, state_nxt;
   logic [AXIS_TDATA_WIDTH-1:0]     h_data_r, o_data_r;
   logic [AXIS_TDATA_WIDTH/8-1:0]   h_keep_r, o_keep_r;
   logic [PID_BITS-1:0]             h_tid_r, o_tid_r;
   logic                            o_last_r, o_valid_r;
   logic [31:0]                     acc_r;
   logic [31:0]                     beat_sum_s;
   logic                            accept_s, ok_set_s, err_set_s, runt_set_s;

   // Sum of the sixteen 32-bit lanes, with bytes whose keep bit is clear counted as zero.
   function automatic logic [31:0] lane_sum(input logic [511:0] data, input logic [63:0] keep);
      logic [511:0] masked;
      logic [31:0]  sum;
      sum = 32'd0;
      for (int b = 0; b < 64; b++) begin
         masked[8*b +: 8] = keep[b] ? data[8*b +: 8] : 8'h00;
      end
      for (int l = 0; l < 16; l++) begin
         sum = sum + masked[32*l +: 32];
      end
      return sum;
   endfunction

   assign s_axis_tready = (state_r == IDLE) | ~o_valid_r | m_axis_tready;
   assign accept_s      = s_axis_tvalid & s_axis_tready;
   assign beat_sum_s    = lane_sum(s_axis_tdata, s_axis_tkeep);

   assign m_axis_tdata  = o_data_r;
   assign m_axis_tkeep  = o_keep_r;
   assign m_axis_tid    = o_tid_r;
   assign m_axis_tlast  = o_last_r;
   assign m_axis_tvalid = o_valid_r;

   // Next-state and checksum verdict decode.
   always_comb begin
      state_nxt  = state_r;
      ok_set_s   = 1'b0;
      err_set_s  = 1'b0;
      runt_set_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s && s_axis_tlast) begin
               err_set_s  = 1'b1;
               runt_set_s = 1'b1;
            end else if (accept_s) begin
               state_nxt = HOLD;
            end else begin
               state_nxt = IDLE;
            end
         end
         HOLD: begin
            if (accept_s && s_axis_tlast) begin
               state_nxt = IDLE;
               // Only the low lane of the checksum beat carries the checksum.
               if ((acc_r == s_axis_tdata[31:0]) && (s_axis_tid == h_tid_r)) begin
                  ok_set_s = 1'b1;
               end else begin
                  err_set_s = 1'b1;
               end
            end else begin
               state_nxt = HOLD;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Hold/output pipeline, running sum and status pulses.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         h_data_r  <= '0;
         h_keep_r  <= '0;
         h_tid_r   <= '0;
         o_data_r  <= '0;
         o_keep_r  <= '0;
         o_tid_r   <= '0;
         o_last_r  <= 1'b0;
         o_valid_r <= 1'b0;
         acc_r     <= 32'd0;
         chk_ok    <= 1'b0;
         chk_err   <= 1'b0;
         runt_err  <= 1'b0;
      end else begin
         chk_ok   <= ok_set_s;
         chk_err  <= err_set_s;
         runt_err <= runt_set_s;
         // The held beat moves out only once its successor shows whether it ends the packet.
         if (accept_s && (state_r == HOLD)) begin
            o_data_r  <= h_data_r;
            o_keep_r  <= h_keep_r;
            o_tid_r   <= h_tid_r;
            o_last_r  <= s_axis_tlast;
            o_valid_r <= 1'b1;
         end else if (o_valid_r && m_axis_tready) begin
            o_valid_r <= 1'b0;
         end
         if (accept_s && !s_axis_tlast) begin
            h_data_r <= s_axis_tdata;
            h_keep_r <= s_axis_tkeep;
            h_tid_r  <= s_axis_tid;
            acc_r    <= (state_r == IDLE) ? beat_sum_s : (acc_r + beat_sum_s);
         end
      end
   end

`ifdef CHK_STATS_EN
   // Wrapping pass/fail packet counters, cleared only by reset.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         pkt_cnt <= 32'd0;
         err_cnt <= 32'd0;
      end else begin
         if (ok_set_s) begin
            pkt_cnt <= pkt_cnt + 32'd1;
         end
         if (err_set_s) begin
            err_cnt <= err_cnt + 32'd1;
         end
      end
   end
`else
   assign pkt_cnt = 32'd0;
   assign err_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_chk_verify_strip.sv
// Self-checking scoreboard bench for chk_verify_strip.
module tb_chk_verify_strip;

   typedef struct packed {
      logic [511:0] data;
      logic [63:0]  keep;
      logic [7:0]   tid;
      logic         last;
   } beat_t;

   logic          aclk = 1'b0;
   logic          areset;
   logic [511:0]  s_tdata, m_tdata;
   logic [63:0]   s_tkeep, m_tkeep;
   logic [7:0]    s_tid, m_tid;
   logic          s_tlast, s_tvalid, s_tready;
   logic          m_tlast, m_tvalid, m_tready;
   logic          chk_ok, chk_err, runt_err;
   logic [31:0]   pkt_cnt, err_cnt;

   int            n_checks = 0;
   int            n_errors = 0;
   beat_t         exp_q[$];
   logic [2:0]    stat_q[$];
   int            ok_cnt_m = 0;
   int            err_cnt_m = 0;
   bit            mid_pkt = 1'b0;
   bit            rmode = 1'b0;

   chk_verify_strip #(.AXIS_TDATA_WIDTH(512), .PID_BITS(8)) dut (
      .aclk(aclk), .areset(areset),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tid(s_tid),
      .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tid(m_tid),
      .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .chk_ok(chk_ok), .chk_err(chk_err), .runt_err(runt_err),
      .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
   );

   always #5 aclk = ~aclk;

   task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference checksum: each byte weighted by its position inside its 32-bit lane.
   function automatic logic [31:0] model_sum(input logic [511:0] data, input logic [63:0] keep);
      logic [31:0] s;
      logic [7:0]  by;
      s = 32'd0;
      for (int b = 0; b < 64; b++) begin
         by = keep[b] ? data[8*b +: 8] : 8'h00;
         s  = s + (32'(by) << (8 * (b % 4)));
      end
      return s;
   endfunction

   function automatic logic [31:0] stat_exp(input int v);
`ifdef CHK_STATS_EN
      return 32'(v);
`else
      return 32'd0 + 32'(v - v);
`endif
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic [7:0] t,
                            input logic l);
      bit got;
      got      = 1'b0;
      s_tdata  = d;
      s_tkeep  = k;
      s_tid    = t;
      s_tlast  = l;
      s_tvalid = 1'b1;
      for (int w = 0; w < 100; w++) begin
         @(negedge aclk);
         if (s_tready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check_val("accept_timeout", 512'd0, 512'd1);
      @(posedge aclk);
      #1;
      s_tvalid = 1'b0;
      if (got) mid_pkt = !l;
   endtask

   task automatic send_pkt(input int n, input logic [31:0] lane, input logic [31:0] step,
                           input logic [63:0] keep, input bit rnd, input bit use_model,
                           input logic [31:0] chk_in, input logic [7:0] tid,
                           input logic [7:0] chk_tid);
      beat_t       b;
      logic [31:0] acc, chk;
      logic [511:0] cd;
      bit          ok;
      acc = 32'd0;
      for (int i = 0; i < n; i++) begin
         for (int l = 0; l < 16; l++) begin
            b.data[32*l +: 32] = rnd ? $urandom : (lane + 32'(i) * step);
         end
         b.keep = rnd ? {$urandom, $urandom} : keep;
         b.tid  = tid;
         b.last = (i == n - 1);
         exp_q.push_back(b);
         acc = acc + model_sum(b.data, b.keep);
         send_beat(b.data, b.keep, tid, 1'b0);
      end
      chk = use_model ? (acc + chk_in) : chk_in;
      ok  = (chk == acc) && (chk_tid == tid);
      stat_q.push_back({ok, !ok, 1'b0});
      if (ok) ok_cnt_m++;
      else err_cnt_m++;
      for (int l = 1; l < 16; l++) cd[32*l +: 32] = $urandom;
      cd[31:0] = chk;
      send_beat(cd, {$urandom, $urandom}, chk_tid, 1'b1);
   endtask

   task automatic check_counters(input string tag);
      check_val({tag, "_pkt_cnt"}, 512'(pkt_cnt), 512'(stat_exp(ok_cnt_m)));
      check_val({tag, "_err_cnt"}, 512'(err_cnt), 512'(stat_exp(err_cnt_m)));
   endtask

   // Downstream ready pattern: always ready, or alternating when rmode is set.
   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         if (rmode) m_tready = ~m_tready;
         else m_tready = 1'b1;
      end
   end

   // Scoreboard: compare every forwarded beat and every status pulse against the queues.
   always @(negedge aclk) begin
      beat_t      e;
      logic [2:0] es;
      if (!areset) begin
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               check_val("beat_unexpected", 512'(m_tvalid), 512'd0);
            end else begin
               e = exp_q.pop_front();
               check_val("beat_data", m_tdata, e.data);
               check_val("beat_keep", 512'(m_tkeep), 512'(e.keep));
               check_val("beat_tid", 512'(m_tid), 512'(e.tid));
               check_val("beat_last", 512'(m_tlast), 512'(e.last));
            end
         end
         if (chk_ok || chk_err || runt_err) begin
            if (stat_q.size() == 0) begin
               check_val("status_unexpected", 512'({chk_ok, chk_err, runt_err}), 512'd0);
            end else begin
               es = stat_q.pop_front();
               check_val("status", 512'({chk_ok, chk_err, runt_err}), 512'(es));
            end
         end
         if (mid_pkt && m_tvalid && !m_tready) begin
            check_val("s_tready_backpressure", 512'(s_tready), 512'd0);
         end
      end
   end

   initial begin
      areset   = 1'b1;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tid    = '0;
      s_tlast  = 1'b0;
      repeat (3) @(negedge aclk);
      check_val("rst_m_tvalid", 512'(m_tvalid), 512'd0);
      check_val("rst_status", 512'({chk_ok, chk_err, runt_err}), 512'd0);
      check_val("rst_pkt_cnt", 512'(pkt_cnt), 512'd0);
      check_val("rst_err_cnt", 512'(err_cnt), 512'd0);
      @(posedge aclk);
      #1;
      areset = 1'b0;
      wait_cycles(1);
      check_val("rst_s_tready", 512'(s_tready), 512'd1);

      // Good packet, then the same packet with a bad checksum.
      send_pkt(3, 32'h1, 32'h0, {64{1'b1}}, 1'b0, 1'b0, 32'd48, 8'd5, 8'd5);
      wait_cycles(4);
      check_counters("pkt_good");
      send_pkt(3, 32'h1, 32'h0, {64{1'b1}}, 1'b0, 1'b0, 32'd47, 8'd5, 8'd5);
      wait_cycles(4);
      check_counters("pkt_bad");

      // Runt: checksum beat with no data beats.
      stat_q.push_back(3'b011);
      err_cnt_m++;
      send_beat({16{32'h1234}}, {64{1'b1}}, 8'd3, 1'b1);
      wait_cycles(4);
      check_counters("runt");

      // Alternating downstream ready.
      rmode = 1'b1;
      send_pkt(4, 32'd5, 32'd1, {64{1'b1}}, 1'b0, 1'b0, 32'd416, 8'd7, 8'd7);
      wait_cycles(8);
      rmode = 1'b0;
      wait_cycles(2);
      check_counters("bp");

      // Masked bytes count as zero.
      send_pkt(1, 32'hFFFF_FFFF, 32'h0, 64'h0F, 1'b0, 1'b0, 32'hFFFF_FFFF, 8'd2, 8'd2);
      send_pkt(1, 32'hFFFF_FFFF, 32'h0, {64{1'b1}}, 1'b0, 1'b0, 32'hFFFF_FFFF, 8'd2, 8'd2);
      wait_cycles(4);
      check_counters("keep");

      // Back-to-back random packets, including a wrong checksum and a tid mismatch.
      for (int p = 0; p < 6; p++) begin
         rmode = (p >= 3);
         send_pkt(1 + (p % 4), 32'h0, 32'h0, 64'h0, 1'b1, 1'b1, (p == 2) ? 32'd1 : 32'd0,
                  8'(p + 16), (p == 4) ? 8'd99 : 8'(p + 16));
      end
      wait_cycles(8);
      rmode = 1'b0;
      wait_cycles(2);
      check_counters("rand");

      // Reset after two of four data beats; the first beat has already left.
      b_first: begin
         beat_t b;
         b.data = {16{32'hA5A5_0001}};
         b.keep = {64{1'b1}};
         b.tid  = 8'd9;
         b.last = 1'b0;
         exp_q.push_back(b);
         send_beat(b.data, b.keep, b.tid, 1'b0);
         send_beat({16{32'hA5A5_0002}}, {64{1'b1}}, 8'd9, 1'b0);
      end
      wait_cycles(2);
      check_val("pre_reset_queue", 512'(exp_q.size()), 512'd0);
      areset = 1'b1;
      wait_cycles(2);
      areset    = 1'b0;
      mid_pkt   = 1'b0;
      ok_cnt_m  = 0;
      err_cnt_m = 0;
      wait_cycles(1);
      check_counters("post_reset");
      send_pkt(2, 32'd3, 32'd0, {64{1'b1}}, 1'b0, 1'b0, 32'd96, 8'd4, 8'd4);
      wait_cycles(6);
      check_counters("clean_after_reset");

      check_val("beats_outstanding", 512'(exp_q.size()), 512'd0);
      check_val("status_outstanding", 512'(stat_q.size()), 512'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
